mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS pipeline memory stage.
- Holds the EX/MEM pipeline register and runs the data-memory access over a req/ready handshake.
- Holds the MEM/WB pipeline register.
- Is the producer of the ALUoutMEM/regwriteaddrMEM/RegWriteMEM and regwritedataWB/regwriteaddrWB/RegWriteWB forwarding sources that the execute stage consumes. Asserts StallMEM to freeze IF/ID/EX while an access is waiting.

Parameters:
- TIMEOUT, 16, maximum wait cycles for dmem_ready before the access is aborted with a bus error (range 1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous reset, active-low (0 = reset)
- intterupt  input  1  interrupt; squashes the instruction entering MEM
- ALUoutEX  input  32  ALU result / memory address from EX
- memwritedataEX  input  32  store data from EX
- regwriteaddrEX  input  5  destination register from EX
- RegWriteEX  input  1  instruction writes a register
- MemReadEX  input  1  instruction is a load
- MemWriteEX  input  1  instruction is a store
- MemtoRegEX  input  1  write-back source: 1 = memory data, 0 = ALU result
- ALUoutMEM  output  32  registered ALU result (forwarding source)
- regwriteaddrMEM  output  5  registered destination (forwarding source)
- RegWriteMEM  output  1  registered write enable (forwarding source)
- regwritedataWB  output  32  write-back data
- regwriteaddrWB  output  5  write-back destination
- RegWriteWB  output  1  write-back enable
- StallMEM  output  1  freeze upstream stages this cycle
- dmem_req  output  1  access request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  word address, equal to ALUoutMEM
- dmem_wdata  output  32  store data
- dmem_rdata  input  32  read data, valid when dmem_ready = 1
- dmem_ready  input  1  access completes this cycle
- buserr  output  1  one-cycle pulse when an access is aborted by timeout

Behaviour:
- Reset (reset = 0 at an edge):
  - Both pipeline registers clear to 0: all data, addresses and enables.
  - FSM goes to IDLE; wait counter = 0.
  - All outputs read 0 on the next cycle.
- Access detection: mem_op = MemReadMEM | MemWriteMEM.
- Request outputs are combinational from the EX/MEM register and FSM state:
  - dmem_req = mem_op while the state is IDLE or WAIT.
  - dmem_we = MemWriteMEM.
  - dmem_addr and dmem_wdata hold stable for the whole request.
- FSM states: IDLE, WAIT.
  - IDLE, mem_op, dmem_ready = 1: zero-wait completion; StallMEM = 0.
  - IDLE, mem_op, dmem_ready = 0: go to WAIT; counter = 1; StallMEM = 1.
  - WAIT, dmem_ready = 1: completes; StallMEM = 0; next state IDLE; counter cleared.
  - WAIT, dmem_ready = 0, counter < TIMEOUT: StallMEM = 1; counter increments.
  - WAIT, dmem_ready = 0, counter == TIMEOUT: abort.
    - buserr = 1 and dmem_req = 0 this cycle; StallMEM = 0.
    - The instruction retires with RegWrite suppressed.
    - Next state IDLE.
- EX/MEM register:
  - Loads from the EX inputs on each edge where StallMEM = 0.
  - Holds its contents on each edge where StallMEM = 1.
- MEM/WB register:
  - If StallMEM = 0, loads regwritedataWB = MemtoRegMEM ? dmem_rdata : ALUoutMEM, plus regwriteaddrWB and RegWriteWB = RegWriteMEM & ~abort.
  - If StallMEM = 1, loads a bubble: RegWriteWB = 0 (data and address don't care, driven 0).
- Load latency: with zero wait states, load data appears on regwritedataWB 2 edges after the instruction leaves EX; each wait cycle adds 1.
- Stores never write back, whatever RegWriteEX is.
- intterupt:
  - If it is high at an edge where EX/MEM loads, RegWriteMEM, MemReadMEM and MemWriteMEM load 0 (bubble).
  - If it is high while stalled, it has no effect: an in-flight bus transaction is never abandoned.
- The reset-0 condition overrides every other event at the same edge, including reset during WAIT.
- Load-use hazards are not handled here: the hazard unit stalls for them. ALUoutMEM carries the address for loads.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- With the macro defined:
  - A mem_op with dmem_addr[1:0] != 0 is a misaligned access.
  - dmem_req is suppressed for it, and output misalign pulses for 1 cycle.
  - The instruction retires with RegWrite suppressed and no stall.
- Without the macro: there is no misalign port, and the address bits [1:0] pass to memory unchecked.

Decomposition:
- Shared package mips_pkg holds the FSM state typedef (IDLE/WAIT), a WORD_W = 32 constant and a REG_ADDR_W = 5 constant.
- One natural sub-module: mem_access_fsm (states, timeout counter, StallMEM, buserr, abort). Both pipeline registers stay in mem_stage.

Test Plan:
- Zero-wait load:
  - Stimulus: MemReadEX = 1, ALUoutEX = 0x100, regwriteaddrEX = 8, MemtoRegEX = 1; dmem_ready tied 1; dmem_rdata = 0xDEADBEEF.
  - Response: StallMEM never 1; 2 edges later regwritedataWB = 0xDEADBEEF, regwriteaddrWB = 8, RegWriteWB = 1.
- Wait-state store:
  - Stimulus: MemWriteEX = 1, addr 0x200, data 0x12345678; dmem_ready = 0 for 3 cycles, then 1.
  - Response: StallMEM = 1 for exactly 3 cycles; dmem_addr/dmem_wdata stable throughout; RegWriteWB stays 0.
- Timeout with TIMEOUT = 4:
  - Stimulus: a load with dmem_ready held 0.
  - Response: StallMEM = 1 for 4 cycles; buserr pulses once; RegWriteWB = 0; FSM returns to IDLE; the next ALU op retires normally.
- ALU forwarding:
  - Stimulus: RegWriteEX = 1, ALUoutEX = 7, regwriteaddrEX = 3, MemtoRegEX = 0.
  - Response: after 1 edge ALUoutMEM = 7, regwriteaddrMEM = 3, RegWriteMEM = 1; after 2 edges regwritedataWB = 7.
- intterupt:
  - Stimulus: intterupt = 1 with a load entering while unstalled.
  - Response: RegWriteMEM = MemReadMEM = 0 and dmem_req stays 0. If intterupt is raised during WAIT instead, the access still completes.
- Reset mid-WAIT:
  - Stimulus: reset = 0 on the 2nd wait cycle.
  - Response: next cycle all outputs are 0, state is IDLE, dmem_req = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths and the memory-access FSM state type.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
    import mips_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [WORD_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Wait-state tracker for one data-memory access: stalls while waiting, aborts after TIMEOUT cycles.
module mem_access_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic memOp,
    input  logic dmemReady,
    output logic StallMEM,
    output logic buserr,
    output logic abort
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    memState_t  state, nextState;
    logic [7:0] waitCnt, nextCnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = waitCnt;
        StallMEM  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (memOp && !dmemReady) begin
                    nextState = WAIT;
                    nextCnt   = 8'd1;
                    StallMEM  = 1'b1;
                end
            end
            WAIT: begin
                // ready wins over the timeout on the final wait cycle
                if (dmemReady) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else if (waitCnt < WAIT_LIMIT) begin
                    StallMEM = 1'b1;
                    nextCnt  = waitCnt + 8'd1;
                end else begin
                    abort     = 1'b1;
                    nextState = IDLE;
                    nextCnt   = '0;
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase
        buserr = abort;
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM and MEM/WB pipeline registers around a req/ready data-memory access.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  intterupt,
    input  logic [WORD_W-1:0]     ALUoutEX,
    input  logic [WORD_W-1:0]     memwritedataEX,
    input  logic [REG_ADDR_W-1:0] regwriteaddrEX,
    input  logic                  RegWriteEX,
    input  logic                  MemReadEX,
    input  logic                  MemWriteEX,
    input  logic                  MemtoRegEX,
    output logic [WORD_W-1:0]     ALUoutMEM,
    output logic [REG_ADDR_W-1:0] regwriteaddrMEM,
    output logic                  RegWriteMEM,
    output logic [WORD_W-1:0]     regwritedataWB,
    output logic [REG_ADDR_W-1:0] regwriteaddrWB,
    output logic                  RegWriteWB,
    output logic                  StallMEM,
    mem_stage_if.master           dmem,
    output logic                  buserr
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic                  misalign
`endif
);

    logic [WORD_W-1:0] memwritedataMEM;
    logic              MemReadMEM;
    logic              MemWriteMEM;
    logic              MemtoRegMEM;
    logic              memOpRaw;
    logic              memOp;
    logic              abort;
    logic              retireKill;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ALUoutMEM       <= '0;
            memwritedataMEM <= '0;
            regwriteaddrMEM <= '0;
            RegWriteMEM     <= 1'b0;
            MemReadMEM      <= 1'b0;
            MemWriteMEM     <= 1'b0;
            MemtoRegMEM     <= 1'b0;
        end else if (!StallMEM) begin
            ALUoutMEM       <= ALUoutEX;
            memwritedataMEM <= memwritedataEX;
            regwriteaddrMEM <= regwriteaddrEX;
            MemtoRegMEM     <= MemtoRegEX;
            RegWriteMEM     <= RegWriteEX & ~intterupt;
            MemReadMEM      <= MemReadEX & ~intterupt;
            MemWriteMEM     <= MemWriteEX & ~intterupt;
        end
    end

    assign memOpRaw = MemReadMEM | MemWriteMEM;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // a misaligned access never reaches the bus or the FSM, so it cannot stall
    assign misalign   = memOpRaw & (ALUoutMEM[1:0] != 2'b00);
    assign memOp      = memOpRaw & ~misalign;
    assign retireKill = abort | misalign;
`else
    assign memOp      = memOpRaw;
    assign retireKill = abort;
`endif

    mem_access_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .memOp    (memOp),
        .dmemReady(dmem.dmem_ready),
        .StallMEM (StallMEM),
        .buserr   (buserr),
        .abort    (abort)
    );

    assign dmem.dmem_req   = memOp & ~abort;
    assign dmem.dmem_we    = MemWriteMEM;
    assign dmem.dmem_addr  = ALUoutMEM;
    assign dmem.dmem_wdata = memwritedataMEM;

    always_ff @(posedge clk) begin
        if (!reset) begin
            regwritedataWB <= '0;
            regwriteaddrWB <= '0;
            RegWriteWB     <= 1'b0;
        end else if (!StallMEM) begin
            regwritedataWB <= MemtoRegMEM ? dmem.dmem_rdata : ALUoutMEM;
            regwriteaddrWB <= regwriteaddrMEM;
            RegWriteWB     <= RegWriteMEM & ~MemWriteMEM & ~retireKill;
        end else begin
            regwritedataWB <= '0;
            regwriteaddrWB <= '0;
            RegWriteWB     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: per-instruction timeline model drives memory latency,
// a scoreboard queue holds expected write-backs, and a monitor retires them.
module tb_mem_stage;
    import mips_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        intterupt = 1'b0;
    logic [31:0] ALUoutEX = '0;
    logic [31:0] memwritedataEX = '0;
    logic [4:0]  regwriteaddrEX = '0;
    logic        RegWriteEX = 1'b0;
    logic        MemReadEX = 1'b0;
    logic        MemWriteEX = 1'b0;
    logic        MemtoRegEX = 1'b0;
    logic [31:0] ALUoutMEM;
    logic [4:0]  regwriteaddrMEM;
    logic        RegWriteMEM;
    logic [31:0] regwritedataWB;
    logic [4:0]  regwriteaddrWB;
    logic        RegWriteWB;
    logic        StallMEM;
    logic        buserr;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .intterupt      (intterupt),
        .ALUoutEX       (ALUoutEX),
        .memwritedataEX (memwritedataEX),
        .regwriteaddrEX (regwriteaddrEX),
        .RegWriteEX     (RegWriteEX),
        .MemReadEX      (MemReadEX),
        .MemWriteEX     (MemWriteEX),
        .MemtoRegEX     (MemtoRegEX),
        .ALUoutMEM      (ALUoutMEM),
        .regwriteaddrMEM(regwriteaddrMEM),
        .RegWriteMEM    (RegWriteMEM),
        .regwritedataWB (regwritedataWB),
        .regwriteaddrWB (regwriteaddrWB),
        .RegWriteWB     (RegWriteWB),
        .StallMEM       (StallMEM),
        .dmem           (bus),
        .buserr         (buserr)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    // typ: 0 = ALU op, 1 = load, 2 = store; lat = cycles before memory answers
    typedef struct {
        int unsigned typ;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        regW;
        int unsigned lat;
        logic        squash;
        logic        marked;
    } instr_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    wb_t         sbq[$];
    logic [31:0] memModel[logic [31:0]];
    int          errors = 0;
    int          checks = 0;
    instr_t      cur, nxt;
    int unsigned k;
    logic        forceQuiet = 1'b0;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic instr_t bubble();
        instr_t r;
        r.typ = 0; r.alu = '0; r.wdata = '0; r.rd = '0; r.regW = 1'b0;
        r.lat = 0; r.squash = 1'b0; r.marked = 1'b0;
        return r;
    endfunction

    function automatic instr_t randInstr();
        instr_t r;
        r = bubble();
        r.typ   = $urandom_range(0, 2);
        r.wdata = $urandom();
        r.rd    = 5'($urandom_range(0, 31));
        r.regW  = ($urandom_range(0, 3) != 0);
        r.lat   = ($urandom_range(0, 3) == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(0, TO);
        if (r.typ != 0 && $urandom_range(0, 1) == 1)
            r.alu = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        else
            r.alu = $urandom();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if (r.typ != 0) r.alu[1:0] = 2'b00;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " ALUoutMEM"}, ALUoutMEM, 32'h0);
        check({tag, " regwriteaddrMEM"}, 32'(regwriteaddrMEM), 32'h0);
        check({tag, " RegWriteMEM"}, 32'(RegWriteMEM), 32'h0);
        check({tag, " regwritedataWB"}, regwritedataWB, 32'h0);
        check({tag, " regwriteaddrWB"}, 32'(regwriteaddrWB), 32'h0);
        check({tag, " RegWriteWB"}, 32'(RegWriteWB), 32'h0);
        check({tag, " StallMEM"}, 32'(StallMEM), 32'h0);
        check({tag, " dmem_req"}, 32'(bus.dmem_req), 32'h0);
        check({tag, " dmem_we"}, 32'(bus.dmem_we), 32'h0);
        check({tag, " dmem_addr"}, bus.dmem_addr, 32'h0);
        check({tag, " dmem_wdata"}, bus.dmem_wdata, 32'h0);
        check({tag, " buserr"}, 32'(buserr), 32'h0);
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step();
        logic memop, ok, lastCycle, expReq, expStall, expErr, rdy, intr;
        wb_t  e;
        ALUoutEX       = nxt.alu;
        memwritedataEX = nxt.wdata;
        regwriteaddrEX = nxt.rd;
        RegWriteEX     = nxt.regW;
        MemReadEX      = (nxt.typ == 1);
        MemWriteEX     = (nxt.typ == 2);
        MemtoRegEX     = (nxt.typ == 1);
        intr = forceQuiet ? 1'b0 : ($urandom_range(0, 7) == 0);
        intterupt = intr;

        memop = !cur.squash && (cur.typ != 0);
        ok    = (cur.lat <= TO);
        if (!memop) begin
            lastCycle = 1'b1; expReq = 1'b0; expStall = 1'b0; expErr = 1'b0;
            rdy = 1'($urandom_range(0, 1));
        end else if (ok) begin
            lastCycle = (k == cur.lat); expReq = 1'b1; expStall = !lastCycle; expErr = 1'b0;
            rdy = lastCycle;
        end else begin
            lastCycle = (k == TO); expReq = !lastCycle; expStall = !lastCycle; expErr = lastCycle;
            rdy = 1'b0;
        end
        bus.dmem_ready = rdy;
        bus.dmem_rdata = (memop && rdy) ? memRead(cur.alu) : $urandom();
        #1;
        check("StallMEM", 32'(StallMEM), 32'(expStall));
        check("dmem_req", 32'(bus.dmem_req), 32'(expReq));
        check("buserr", 32'(buserr), 32'(expErr));
        if (expReq) begin
            check("dmem_addr", bus.dmem_addr, cur.alu);
            check("dmem_we", 32'(bus.dmem_we), 32'(cur.typ == 2));
            if (cur.typ == 2) check("dmem_wdata", bus.dmem_wdata, cur.wdata);
        end
        if (k == 0) begin
            check("ALUoutMEM", ALUoutMEM, cur.alu);
            check("regwriteaddrMEM", 32'(regwriteaddrMEM), 32'(cur.rd));
            if (cur.typ != 2) check("RegWriteMEM", 32'(RegWriteMEM), 32'(cur.regW & !cur.squash));
        end
        if (lastCycle) begin
            if (!cur.squash) begin
                if (cur.typ == 0 && cur.regW) begin
                    e.data = cur.alu; e.rd = cur.rd; sbq.push_back(e);
                end else if (cur.typ == 1 && cur.regW && ok) begin
                    e.data = memRead(cur.alu); e.rd = cur.rd; sbq.push_back(e);
                end else if (cur.typ == 2 && ok) begin
                    memModel[cur.alu] = cur.wdata;
                end
            end
            cur = nxt;
            cur.squash = intr;
            nxt = randInstr();
            k = 0;
        end else begin
            k++;
        end
        @(negedge clk);
    endtask

    // Write-back monitor, sampling between the rising and falling edges.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #3;
            if (RegWriteWB === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_writeback: got rd=%0d data=%h expected none (t=%0t)",
                             regwriteaddrWB, regwritedataWB, $time);
                end else begin
                    e = sbq.pop_front();
                    check("regwritedataWB", regwritedataWB, e.data);
                    check("regwriteaddrWB", 32'(regwriteaddrWB), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        bit reached;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");

        reset = 1'b1;
        cur = bubble();
        nxt = randInstr();
        k = 0;
        repeat (600) step();

        // Drive a long-latency load into WAIT, then reset on its second wait cycle.
        forceQuiet = 1'b1;
        nxt = bubble();
        nxt.typ = 1; nxt.alu = 32'h100; nxt.rd = 5'd8; nxt.regW = 1'b1;
        nxt.lat = 99; nxt.marked = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cur.marked && k == 2) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        check("reach_wait_for_reset", 32'(reached), 32'h1);
        reset = 1'b0;
        bus.dmem_ready = 1'b0;
        sbq.delete();
        @(negedge clk);
        checkAllZero("midwait_reset");

        reset = 1'b1;
        forceQuiet = 1'b0;
        cur = bubble();
        nxt = randInstr();
        k = 0;
        repeat (200) step();
        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
